mc_fifo: RTL and testbench
==========================

// Module: mc_fifo
// PURPOSE
//  Multi-channel synchronous FIFO for router input ports: NUM_CH independent queues behind one shared push bus and one shared pop bus.
//  Each channel has its own full/empty/almost flags, occupancy count and sticky overflow/underflow error bits.
//  Sits between the port deserialiser (push side) and the crossbar arbiter (pop side).
// PARAMETERS
//  WIDTH       32        data word width in bits
//  DEPTH       128       entries per channel; power of 2, >= 4
//  NUM_CH      4         number of channels; power of 2, >= 2
//  AFULL_LVL   DEPTH-4   afull[c] is 1 when count[c] >= AFULL_LVL
//  AEMPTY_LVL  4         aempty[c] is 1 when count[c] <= AEMPTY_LVL
// PORTS
//  clock       in   1                 rising-edge clock
//  reset_n     in   1                 asynchronous, active-low reset
//  push        in   1                 write request
//  push_ch     in   CH_W              target channel of the write
//  din         in   WIDTH             write data
//  pop         in   1                 read request
//  pop_ch      in   CH_W              source channel of the read
//  dout        out  WIDTH             read data, registered
//  dout_valid  out  1                 1-cycle pulse: dout holds a popped word
//  full        out  NUM_CH            per-channel full flag
//  empty       out  NUM_CH            per-channel empty flag
//  afull       out  NUM_CH            per-channel almost-full flag
//  aempty      out  NUM_CH            per-channel almost-empty flag
//  count       out  NUM_CH*(AW+1)     packed per-channel occupancy; channel c at [c*(AW+1) +: AW+1]
//  ovf         out  NUM_CH            sticky: push attempted to a full channel
//  udf         out  NUM_CH            sticky: pop attempted from an empty channel
//  clr_err     in   1                 synchronous clear of ovf and udf
//  peak        out  NUM_CH*(AW+1)     per-channel high-water mark (see CONFIGURATION)
// BEHAVIOUR
//  - Clock and reset: reset clock-edge-independent. Reset values: all pointers, count, ovf, udf, peak, dout and dout_valid = 0; empty = all 1; full, afull = 0; aempty = all 1. Memory contents are not reset.
//  - Width rules: CH_W = log2(NUM_CH); AW = log2(DEPTH). Pointers are AW bits and wrap naturally from DEPTH-1 to 0. Count is AW+1 bits, range 0..DEPTH.
//  - Flags: full/empty/afull/aempty are combinational decodes of the registered counts, so they reflect state at the start of the cycle.
//  - Push: accepted iff push && !full[push_ch]. din is written at wr_ptr; wr_ptr++; count++ on the next edge.
//    A rejected push sets ovf[push_ch] and leaves all state unchanged.
//  - Pop: accepted iff pop && !empty[pop_ch]. rd_ptr++ and count-- take effect at the same edge.
//    dout <= mem[pop_ch][rd_ptr] and dout_valid <= 1 at that edge, so read latency is 1 cycle.
//    Otherwise dout_valid <= 0 and dout holds its last value. A rejected pop sets udf[pop_ch].
//  - Push and pop on the same channel, same cycle: both are evaluated against start-of-cycle flags, so count is unchanged.
//    On an empty channel, the pop is rejected (no bypass) and the push is accepted.
//    On a full channel, the pop is accepted and the push is rejected; the caller retries next cycle.
//  - Push and pop on different channels proceed fully independently.
//  - clr_err: clears ovf/udf at the edge. A new error in the same cycle as clr_err wins, so the bit is set.
//  - Reset mid-operation: all channels are emptied immediately. A pending dout_valid is dropped.
// CONFIGURATION
//  - Macro: MC_FIFO_PEAK_EN.
//  - When defined: peak[c] <= max(peak[c], next count[c]) every cycle. peak is cleared by reset and by clr_err; a same-cycle update wins over the clear.
//  - When undefined: no peak registers are built and peak is tied to 0.
// STRUCTURE
//  - Package router_fifo_pkg: the clog2 helper function, the ch_idx_t / ptr_t / cnt_t typedefs, and the DEFAULT_WIDTH/DEFAULT_DEPTH constants.
//  - Sub-module fifo_chan: one channel's storage, pointers, count, flags and error bits. It has per-channel push_en/pop_en inputs and a registered rd_data output.
//  - mc_fifo contains NUM_CH fifo_chan instances (generate loop), the push_ch/pop_ch decoders, the dout mux and the dout_valid register.
// TESTING
//  - Reset: hold reset_n=0 -> empty=4'hF, full=0, count=0, dout_valid=0. Assert reset_n=0 mid-traffic -> the same values appear with no clock edge.
//  - Fill ch2 with 128 words 0..127 -> full[2]=1 at count=128; afull[2]=1 from count=124.
//    A 129th push sets ovf[2] and leaves count at 128. Other channels stay empty.
//  - Drain ch2 -> dout=0,1,...,127 with dout_valid one cycle after each pop, and pointers wrap correctly.
//    A further pop sets udf[2]. clr_err clears ovf and udf.
//  - Interleave: push A to ch0 and B to ch3 alternately with concurrent pops -> per-channel order is preserved and there is no cross-channel leakage.
//  - Same-cycle push+pop on ch1 at count=5 -> count stays 5. On empty ch1 -> count=1 and udf[1]=1.
//    On full ch1 -> count=127 and ovf[1]=1.
//  - MC_FIFO_PEAK_EN: push 10, pop 6, push 3 to ch0 -> peak[0]=10. clr_err -> peak[0]=7.
//    Without the macro, peak stays 0 throughout.

Source files
------------

// File: rtl/mc_fifo_pkg.sv
// router_fifo_pkg: shared constants, width helper and default-size typedefs
// for the multi-channel router FIFO (mc_fifo) and its channel sub-module.
// Optional feature macro used by this slice: MC_FIFO_PEAK_EN.
package router_fifo_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_DEPTH  = 128;
  localparam int DEFAULT_NUM_CH = 4;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  typedef logic [clog2(DEFAULT_NUM_CH)-1:0] ch_idx_t;
  typedef logic [clog2(DEFAULT_DEPTH)-1:0]  ptr_t;
  typedef logic [clog2(DEFAULT_DEPTH):0]    cnt_t;

endpackage

// File: rtl/mc_fifo_if.sv
// mc_fifo_if: push/pop/status bus of the multi-channel FIFO.
//   master : deserialiser/arbiter side, drives push, push_ch, din, pop,
//            pop_ch, clr_err; observes dout, dout_valid and per-channel
//            full/empty/afull/aempty/count/ovf/udf/peak.
//   slave  : the FIFO itself (mc_fifo).
// peak is only populated when MC_FIFO_PEAK_EN is defined (else tied to 0).
interface mc_fifo_if import router_fifo_pkg::*; #(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int NUM_CH = DEFAULT_NUM_CH
) ();
  localparam int CH_W = clog2(NUM_CH);
  localparam int CW   = clog2(DEPTH) + 1;

  logic                 push;
  logic [CH_W-1:0]      push_ch;
  logic [WIDTH-1:0]     din;
  logic                 pop;
  logic [CH_W-1:0]      pop_ch;
  logic                 clr_err;
  logic [WIDTH-1:0]     dout;
  logic                 dout_valid;
  logic [NUM_CH-1:0]    full;
  logic [NUM_CH-1:0]    empty;
  logic [NUM_CH-1:0]    afull;
  logic [NUM_CH-1:0]    aempty;
  logic [NUM_CH*CW-1:0] count;
  logic [NUM_CH-1:0]    ovf;
  logic [NUM_CH-1:0]    udf;
  logic [NUM_CH*CW-1:0] peak;

  modport master (
    output push, push_ch, din, pop, pop_ch, clr_err,
    input  dout, dout_valid, full, empty, afull, aempty, count, ovf, udf, peak
  );

  modport slave (
    input  push, push_ch, din, pop, pop_ch, clr_err,
    output dout, dout_valid, full, empty, afull, aempty, count, ovf, udf, peak
  );
endinterface

// File: rtl/mc_fifo_chan.sv
// fifo_chan: one channel of mc_fifo - storage, pointers, occupancy count,
// flags, sticky overflow/underflow bits and optional high-water mark.
// Ports: clock, reset_n (async, active-low); push_en_i/pop_en_i are the
// decoded requests for this channel (acceptance is decided here against the
// start-of-cycle flags); din_i write data; clr_err_i clears ovf/udf (and peak);
// rd_data_o registered word of the last accepted pop; full/empty/afull/aempty,
// count_o, ovf_o, udf_o, peak_o status. Macro: MC_FIFO_PEAK_EN.
module fifo_chan import router_fifo_pkg::*; #(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AFULL_LVL  = DEPTH - 4,
  parameter int AEMPTY_LVL = 4,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_en_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_en_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             afull_o,
  output logic             aempty_o,
  output logic [AW:0]      count_o,
  output logic             ovf_o,
  output logic             udf_o,
  output logic [AW:0]      peak_o
);

  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_LVL);
  localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_LVL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             push_ok, pop_ok;

  assign full_o   = (cnt_q == DEPTH_C);
  assign empty_o  = (cnt_q == '0);
  assign afull_o  = (cnt_q >= AFULL_C);
  assign aempty_o = (cnt_q <= AEMPTY_C);

  assign push_ok = push_en_i && !full_o;
  assign pop_ok  = pop_en_i  && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // A new error in the same cycle as clr_err wins over the clear.
  always_comb begin
    ovf_d = clr_err_i ? 1'b0 : ovf_q;
    udf_d = clr_err_i ? 1'b0 : udf_q;
    if (push_en_i && full_o) ovf_d = 1'b1;
    if (pop_en_i && empty_o) udf_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign rd_data_o = rd_data_q;
  assign count_o   = cnt_q;
  assign ovf_o     = ovf_q;
  assign udf_o     = udf_q;

`ifdef MC_FIFO_PEAK_EN
  logic [AW:0] peak_q, peak_d;

  // On clr_err the mark restarts from the new count, so that count wins.
  always_comb begin
    peak_d = clr_err_i ? '0 : peak_q;
    if (cnt_d > peak_d) peak_d = cnt_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) peak_q <= '0;
    else          peak_q <= peak_d;
  end

  assign peak_o = peak_q;
`else
  assign peak_o = '0;
`endif

endmodule

// File: rtl/mc_fifo.sv
// mc_fifo: NUM_CH independent FIFO queues behind one shared push bus and one
// shared pop bus (router input port, deserialiser -> crossbar arbiter).
// Ports: clock, reset_n (async, active-low), bus (mc_fifo_if.slave) carrying
// push/push_ch/din, pop/pop_ch, clr_err, registered dout with 1-cycle
// dout_valid pulse, and per-channel full/empty/afull/aempty/count/ovf/udf/peak.
// Macro: MC_FIFO_PEAK_EN enables per-channel high-water marks on bus.peak.
module mc_fifo import router_fifo_pkg::*; #(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int NUM_CH     = DEFAULT_NUM_CH,
  parameter int AFULL_LVL  = DEPTH - 4,
  parameter int AEMPTY_LVL = 4
) (
  input  logic      clock,
  input  logic      reset_n,
  mc_fifo_if.slave  bus
);

  localparam int CH_W = clog2(NUM_CH);
  localparam int CW   = clog2(DEPTH) + 1;

  logic [NUM_CH-1:0] push_req, pop_req;
  logic [WIDTH-1:0]  rd_data [NUM_CH];
  logic [CH_W-1:0]   last_ch_q;
  logic              dout_valid_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign push_req[c] = bus.push && (bus.push_ch == CH_W'(c));
    assign pop_req[c]  = bus.pop  && (bus.pop_ch  == CH_W'(c));

    fifo_chan #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .AFULL_LVL  (AFULL_LVL),
      .AEMPTY_LVL (AEMPTY_LVL)
    ) u_chan (
      .clock     (clock),
      .reset_n   (reset_n),
      .push_en_i (push_req[c]),
      .din_i     (bus.din),
      .pop_en_i  (pop_req[c]),
      .clr_err_i (bus.clr_err),
      .rd_data_o (rd_data[c]),
      .full_o    (bus.full[c]),
      .empty_o   (bus.empty[c]),
      .afull_o   (bus.afull[c]),
      .aempty_o  (bus.aempty[c]),
      .count_o   (bus.count[c*CW +: CW]),
      .ovf_o     (bus.ovf[c]),
      .udf_o     (bus.udf[c]),
      .peak_o    (bus.peak[c*CW +: CW])
    );
  end

  // Each channel registers its own popped word; dout selects the channel of
  // the most recent accepted pop, which holds until that channel pops again.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dout_valid_q <= 1'b0;
      last_ch_q    <= '0;
    end else begin
      dout_valid_q <= bus.pop && !bus.empty[bus.pop_ch];
      if (bus.pop && !bus.empty[bus.pop_ch]) last_ch_q <= bus.pop_ch;
    end
  end

  assign bus.dout       = rd_data[last_ch_q];
  assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mc_fifo.sv
// Self-checking bench for mc_fifo: a queue-based model of the channels is
// stepped alongside the stimulus and compared on every falling clock edge;
// directed literal checks pin the model at key points.
module tb_mc_fifo;
  localparam int W  = 32;
  localparam int D  = 128;
  localparam int N  = 4;
  localparam int CW = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  mc_fifo_if #(.WIDTH(W), .DEPTH(D), .NUM_CH(N)) bus ();

  mc_fifo #(
    .WIDTH(W), .DEPTH(D), .NUM_CH(N), .AFULL_LVL(D-4), .AEMPTY_LVL(4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] mq [N][$];
  logic [N-1:0] m_ovf, m_udf;
  logic [W-1:0] m_dout;
  logic         m_dv;
  int           m_peak [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      mq[c].delete();
      m_peak[c] = 0;
    end
    m_ovf  = '0;
    m_udf  = '0;
    m_dout = '0;
    m_dv   = 1'b0;
  endtask

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic cyc(input logic ps, input int pc, input logic [W-1:0] d,
                     input logic pp, input int qc, input logic clr);
    bit pfull, pempty;
    bus.push = ps; bus.push_ch = 2'(pc); bus.din = d;
    bus.pop  = pp; bus.pop_ch  = 2'(qc); bus.clr_err = clr;
    @(posedge clock);
    if (reset_n) begin
      pfull  = (mq[pc].size() == D);
      pempty = (mq[qc].size() == 0);
      if (clr) begin m_ovf = '0; m_udf = '0; end
      m_dv = 1'b0;
      if (pp) begin
        if (pempty) m_udf[qc] = 1'b1;
        else begin m_dout = mq[qc].pop_front(); m_dv = 1'b1; end
      end
      if (ps) begin
        if (pfull) m_ovf[pc] = 1'b1;
        else       mq[pc].push_back(d);
      end
      for (int c = 0; c < N; c++) begin
        if (clr) m_peak[c] = mq[c].size();
        else if (mq[c].size() > m_peak[c]) m_peak[c] = mq[c].size();
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // Compare process: every status output against the model.
  always @(negedge clock) begin
    logic [N-1:0]    e_full, e_empty, e_afull, e_aempty;
    logic [N*CW-1:0] e_cnt, e_peak;
    for (int c = 0; c < N; c++) begin
      e_full[c]   = (mq[c].size() == D);
      e_empty[c]  = (mq[c].size() == 0);
      e_afull[c]  = (mq[c].size() >= D-4);
      e_aempty[c] = (mq[c].size() <= 4);
      e_cnt[c*CW +: CW] = CW'(mq[c].size());
`ifdef MC_FIFO_PEAK_EN
      e_peak[c*CW +: CW] = CW'(m_peak[c]);
`else
      e_peak[c*CW +: CW] = '0;
`endif
    end
    chk("full",       bus.full,       e_full);
    chk("empty",      bus.empty,      e_empty);
    chk("afull",      bus.afull,      e_afull);
    chk("aempty",     bus.aempty,     e_aempty);
    chk("count",      bus.count,      e_cnt);
    chk("ovf",        bus.ovf,        m_ovf);
    chk("udf",        bus.udf,        m_udf);
    chk("dout_valid", bus.dout_valid, m_dv);
    chk("dout",       bus.dout,       m_dout);
    chk("peak",       bus.peak,       e_peak);
  end

  initial begin
    bus.push = 0; bus.push_ch = '0; bus.din = '0;
    bus.pop = 0; bus.pop_ch = '0; bus.clr_err = 0;
    model_reset();
    #1;
    chk("rst_empty",  bus.empty, 4'hF);
    chk("rst_full",   bus.full, 4'h0);
    chk("rst_count",  bus.count, 32'h0);
    chk("rst_dv",     bus.dout_valid, 1'b0);
    chk("rst_aempty", bus.aempty, 4'hF);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(2);

    // Fill channel 2 with 0..127.
    for (int i = 0; i < D; i++) begin
      cyc(1, 2, W'(i), 0, 0, 0);
      if (i == 122) chk("afull_at_123", bus.afull[2], 1'b0);
      if (i == 123) chk("afull_at_124", bus.afull[2], 1'b1);
    end
    chk("fill_full",  bus.full, 4'h4);
    chk("fill_cnt",   bus.count[2*CW +: CW], 8'd128);
    chk("fill_empty", bus.empty, 4'hB);
    cyc(1, 2, 32'hDEAD_BEEF, 0, 0, 0);
    chk("ovf2",       bus.ovf, 4'h4);
    chk("ovf_cnt",    bus.count[2*CW +: CW], 8'd128);

    // Drain channel 2.
    for (int i = 0; i < D; i++) begin
      cyc(0, 0, '0, 1, 2, 0);
      chk("drain_dv",   bus.dout_valid, 1'b1);
      chk("drain_dout", bus.dout, 64'(i));
    end
    idle(1);
    chk("drain_dv_off", bus.dout_valid, 1'b0);
    chk("drain_hold",   bus.dout, 64'd127);
    cyc(0, 0, '0, 1, 2, 0);
    chk("udf2",       bus.udf, 4'h4);
    chk("udf_dv",     bus.dout_valid, 1'b0);
    cyc(0, 0, '0, 0, 0, 1);
    chk("clr_ovf",    bus.ovf, 4'h0);
    chk("clr_udf",    bus.udf, 4'h0);

    // Interleave ch0/ch3 with concurrent pops (model checks order/isolation).
    for (int i = 0; i < 40; i++) begin
      cyc(1, (i % 2) ? 3 : 0, (i % 2) ? 32'hB000_0000 + W'(i) : 32'hA000_0000 + W'(i),
          i >= 3, (i % 2) ? 0 : 3, 0);
    end
    chk("ilv_first_b", mq[3].size() > 0, 1'b1);

    // Reset in mid-traffic with a dout_valid pending.
    cyc(1, 0, 32'hA0A0_A0A0, 1, 3, 0);
    chk("pre_rst_dv", bus.dout_valid, 1'b1);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("mid_empty",  bus.empty, 4'hF);
    chk("mid_full",   bus.full, 4'h0);
    chk("mid_count",  bus.count, 32'h0);
    chk("mid_dv",     bus.dout_valid, 1'b0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(1);

    // Same-cycle push+pop on ch1.
    cyc(1, 1, 32'h11, 1, 1, 0);
    chk("pp_empty_cnt", bus.count[1*CW +: CW], 8'd1);
    chk("pp_empty_udf", bus.udf, 4'h2);
    for (int i = 0; i < 4; i++) cyc(1, 1, 32'h12 + W'(i), 0, 0, 0);
    chk("pp_cnt5", bus.count[1*CW +: CW], 8'd5);
    cyc(1, 1, 32'h20, 1, 1, 0);
    chk("pp_mid_cnt",  bus.count[1*CW +: CW], 8'd5);
    chk("pp_mid_dout", bus.dout, 64'h11);
    for (int i = 0; i < D-5; i++) cyc(1, 1, 32'h100 + W'(i), 0, 0, 0);
    chk("pp_full_pre", bus.count[1*CW +: CW], 8'd128);
    cyc(1, 1, 32'h999, 1, 1, 0);
    chk("pp_full_cnt", bus.count[1*CW +: CW], 8'd127);
    chk("pp_full_ovf", bus.ovf, 4'h2);

    // High-water mark.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1, 0, W'(i), 0, 0, 0);
    for (int i = 0; i < 6; i++)  cyc(0, 0, '0, 1, 0, 0);
    for (int i = 0; i < 3; i++)  cyc(1, 0, W'(i), 0, 0, 0);
    chk("pk_cnt", bus.count[0 +: CW], 8'd7);
`ifdef MC_FIFO_PEAK_EN
    chk("peak10", bus.peak[0 +: CW], 8'd10);
`else
    chk("peak_off", bus.peak, 32'h0);
`endif
    cyc(0, 0, '0, 0, 0, 1);
`ifdef MC_FIFO_PEAK_EN
    chk("peak_clr", bus.peak[0 +: CW], 8'd7);
`else
    chk("peak_off_clr", bus.peak, 32'h0);
`endif
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
